bpu_update_sched: RTL and testbench
===================================

Name: bpu_update_sched

Overview:
- Schedules branch-resolution updates from the two execute lanes into the single write port of the BTB/PHT prediction table.
- Buffers updates in program order (lane 1 before lane 2) in a small FIFO and drains one update per accepted write.
- Sequences table invalidation sweeps after reset and on request.
- Sits between the execute-stage update buses and the predictor table write port; signals the fetch-side predictor to suppress predictions while a sweep is running.

Parameters:
- DEPTH, 8, FIFO entries; power of 2, minimum 2.
- IDX_W, 7, table index width; the table has 2^IDX_W entries.
- CNT_W, 16, width of the saturating drop counter.

Ports:
- clk  in  1  clock. One clock domain; reset is synchronous and active-high.
- reset  in  1  synchronous active-high reset.
- upd1_valid  in  1  lane-1 resolved branch update.
- upd1_pc  in  32  lane-1 branch PC.
- upd1_taken  in  1  lane-1 actual direction.
- upd1_target  in  32  lane-1 resolved target.
- upd1_type  in  2  lane-1 jump type (00 plain, 01 call, 10 return).
- upd2_valid, upd2_pc, upd2_taken, upd2_target, upd2_type  in  1/32/1/32/2  lane-2 equivalents; lane 2 is younger than lane 1.
- clear_req  in  1  one-cycle pulse requesting full table invalidation.
- wr_ready  in  1  table accepts a write this cycle.
- wr_en  out  1  write request.
- wr_clear  out  1  write invalidates entry wr_idx (data fields are 0).
- wr_idx  out  IDX_W  table index.
- wr_pc  out  32  update PC.
- wr_taken  out  1  update direction.
- wr_target  out  32  update target.
- wr_type  out  2  update jump type.
- busy  out  1  sweep in progress; predictor must suppress predictions.
- fifo_count  out  $clog2(DEPTH)+1  occupied FIFO entries.
- drop_cnt  out  CNT_W  updates dropped because the FIFO was full; saturates at all-ones.

Behaviour:
- States: INIT, RUN, CLEAR. INIT and CLEAR behave identically (sweep); they differ only in entry cause.

Reset:
- state=INIT, sweep index clr_idx=0, FIFO empty, drop_cnt=0.
- Outputs during reset: busy=1, wr_en=1, wr_clear=1, wr_idx=0, data outputs 0, fifo_count=0.
- Reset asserted mid-sweep or mid-drain restarts from these values. Pending updates are lost.

Sweep (INIT/CLEAR):
- wr_en=1, wr_clear=1, wr_idx=clr_idx, busy=1.
- clr_idx increments only on a cycle where wr_ready=1.
- When clr_idx = 2^IDX_W-1 and wr_ready=1: next state RUN, clr_idx returns to 0.
- The sweep therefore takes exactly 2^IDX_W cycles when wr_ready is held high.
- Incoming updates are discarded and do not increment drop_cnt.
- clear_req is ignored during a sweep; the sweep does not restart.

RUN:
- busy=0, wr_clear=0.
- wr_en = FIFO not empty. Data outputs are driven combinationally from the FIFO head.
- wr_idx = head pc[IDX_W+1:2].
- Dequeue on wr_en && wr_ready.
- While wr_en=1 and wr_ready=0, all wr_* outputs hold stable.

Enqueue (RUN only):
- free = DEPTH - fifo_count, using the count at the start of the cycle. A same-cycle dequeue does not create space.
- Both lanes valid:
  - free>=2: enqueue lane 1, then lane 2.
  - free==1: enqueue lane 1, drop lane 2, drop_cnt+1.
  - free==0: drop both, drop_cnt+2.
- One lane valid: enqueue if free>=1, else drop_cnt+1.
- Only lane 2 valid: it takes the slot lane 1 would have taken.
- Taken and not-taken updates are both enqueued; the PHT needs both.

FIFO mechanics:
- Storage is registered. Read/write pointers wrap modulo DEPTH.
- fifo_count = count + enqueued - dequeued, updated each edge.
- Latency: an update enqueued at edge N into an empty FIFO appears on wr_* in the cycle after edge N. There is no bypass from upd* to wr*.

clear_req in RUN:
- At the next edge: state=CLEAR, FIFO emptied (count=0, pointers=0), clr_idx=0.
- Any same-cycle updates and any same-cycle dequeue are discarded.
- The write in flight on that cycle still completes if wr_ready=1.

drop_cnt:
- Saturating; the +2 case stops at all-ones.
- Cleared only by reset.

Test Plan:
1. Sweep after reset: deassert reset, wr_ready=1, IDX_W=7 -> busy=1 and wr_clear=1 for 128 cycles, wr_idx steps 0..127; the next cycle busy=0, wr_en=0, fifo_count=0.
2. Single update: after the sweep, upd1 {pc=0x1C000104, taken=1, target=0x1C000200, type=01} for one cycle -> next cycle wr_en=1, wr_idx=0x41, wr_target=0x1C000200, wr_type=01, fifo_count=1; with wr_ready=1, the following cycle wr_en=0, fifo_count=0.
3. Dual-lane ordering: upd1 pc=0x1C000010 and upd2 pc=0x1C000014 in the same cycle, wr_ready=1 -> wr_idx=0x04 on cycle N+1, then 0x05 on cycle N+2.
4. Overflow: DEPTH=8, wr_ready=0, dual updates for 5 consecutive cycles -> fifo_count=8 after cycle 4; cycle 5 drops both, drop_cnt=2. Then one dual update with count=7 after one dequeue -> lane 1 kept, drop_cnt=3.
5. Stall hold: head pending, wr_ready=0 for 10 cycles while new updates enqueue -> wr_* stable throughout; wr_ready=1 pops the head, then entries drain in order.
6. Clear with pending entries: 3 entries pending, clear_req pulse -> fifo_count=0 next cycle, busy=1 for a 128-cycle sweep; none of the 3 updates ever appears with wr_clear=0, and drop_cnt is unchanged.

Source files
------------

// File: rtl/bpu_update_sched.sv
// bpu_update_sched: orders two-lane branch updates into one table write port and runs invalidation sweeps
module bpu_update_sched #(
    parameter int DEPTH = 8,
    parameter int IDX_W = 7,
    parameter int CNT_W = 16
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    upd1_valid,
    input  logic [31:0]             upd1_pc,
    input  logic                    upd1_taken,
    input  logic [31:0]             upd1_target,
    input  logic [1:0]              upd1_type,
    input  logic                    upd2_valid,
    input  logic [31:0]             upd2_pc,
    input  logic                    upd2_taken,
    input  logic [31:0]             upd2_target,
    input  logic [1:0]              upd2_type,
    input  logic                    clear_req,
    input  logic                    wr_ready,
    output logic                    wr_en,
    output logic                    wr_clear,
    output logic [IDX_W-1:0]        wr_idx,
    output logic [31:0]             wr_pc,
    output logic                    wr_taken,
    output logic [31:0]             wr_target,
    output logic [1:0]              wr_type,
    output logic                    busy,
    output logic [$clog2(DEPTH):0]  fifo_count,
    output logic [CNT_W-1:0]        drop_cnt
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int EW = 67;
    localparam int DW = CNT_W + 1;

    typedef enum logic [1:0] {INIT, RUN, CLEAR} state_t;

    state_t           state_q, state_d;
    logic [IDX_W-1:0] clr_idx_q, clr_idx_d;
    logic [AW-1:0]    wp_q, wp_d, rp_q, rp_d;
    logic [CW-1:0]    cnt_q, cnt_d, free;
    logic [CNT_W-1:0] drop_q, drop_d;
    logic [DW-1:0]    drop_sum;
    logic [EW-1:0]    mem_q [DEPTH];
    logic [EW-1:0]    mem_d [DEPTH];
    logic [EW-1:0]    ent1, ent2, head;
    logic             run, sweep, deq, e1, e2;
    logic [1:0]       ndrop;

    assign ent1  = {upd1_type, upd1_target, upd1_taken, upd1_pc};
    assign ent2  = {upd2_type, upd2_target, upd2_taken, upd2_pc};
    assign head  = mem_q[rp_q];
    assign run   = state_q == RUN;
    assign sweep = !run;

    // Write port: sweep writes clear entries, otherwise the FIFO head is presented
    always_comb begin
        wr_en      = sweep || cnt_q != '0;
        wr_clear   = sweep;
        busy       = sweep;
        wr_idx     = sweep ? clr_idx_q : head[IDX_W+1:2];
        wr_pc      = sweep ? '0 : head[31:0];
        wr_taken   = sweep ? 1'b0 : head[32];
        wr_target  = sweep ? '0 : head[64:33];
        wr_type    = sweep ? '0 : head[66:65];
        fifo_count = cnt_q;
        drop_cnt   = drop_q;
    end

    // Next state: free space is judged on the start-of-cycle count, so a same-cycle pop never makes room
    always_comb begin
        free      = CW'(DEPTH) - cnt_q;
        deq       = run && cnt_q != '0 && wr_ready;
        e1        = run && upd1_valid && free != '0;
        e2        = run && upd2_valid && (upd1_valid ? free >= CW'(2) : free != '0);
        ndrop     = 2'(run && upd1_valid && !e1) + 2'(run && upd2_valid && !e2);
        drop_sum  = {1'b0, drop_q} + DW'(ndrop);
        state_d   = state_q;
        clr_idx_d = clr_idx_q;
        wp_d      = wp_q + AW'(e1) + AW'(e2);
        rp_d      = rp_q + AW'(deq);
        cnt_d     = cnt_q + CW'(e1) + CW'(e2) - CW'(deq);
        drop_d    = drop_sum[CNT_W] ? '1 : drop_sum[CNT_W-1:0];
        mem_d     = mem_q;
        if (e1)
            mem_d[wp_q] = ent1;
        if (e2)
            mem_d[e1 ? wp_q + AW'(1) : wp_q] = ent2;
        if (sweep && wr_ready) begin
            clr_idx_d = clr_idx_q + IDX_W'(1);
            state_d   = &clr_idx_q ? RUN : state_q;
        end
        if (run && clear_req) begin
            state_d   = CLEAR;
            clr_idx_d = '0;
            wp_d      = '0;
            rp_d      = '0;
            cnt_d     = '0;
            drop_d    = drop_q;
        end
    end

    // Control registers; reset restarts the sweep and forgets pending updates
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= INIT;
            clr_idx_q <= '0;
            wp_q      <= '0;
            rp_q      <= '0;
            cnt_q     <= '0;
            drop_q    <= '0;
        end else begin
            state_q   <= state_d;
            clr_idx_q <= clr_idx_d;
            wp_q      <= wp_d;
            rp_q      <= rp_d;
            cnt_q     <= cnt_d;
            drop_q    <= drop_d;
        end
    end

    // FIFO storage needs no reset; occupancy is tracked by the count
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end
endmodule

// File: tb/tb_bpu_update_sched.sv
// tb_bpu_update_sched: randomized scoreboard bench for the branch update scheduler
module tb_bpu_update_sched;
    localparam int DEPTH = 8;
    localparam int IDX_W = 7;
    localparam int CNT_W = 5;
    localparam int TBL   = 1 << IDX_W;
    localparam int DMAX  = (1 << CNT_W) - 1;

    typedef struct {
        logic [31:0] pc;
        logic        taken;
        logic [31:0] target;
        logic [1:0]  typ;
    } ent_t;

    logic clk = 0, reset = 1;
    logic upd1_valid = 0, upd1_taken = 0, upd2_valid = 0, upd2_taken = 0;
    logic [31:0] upd1_pc = 0, upd1_target = 0, upd2_pc = 0, upd2_target = 0;
    logic [1:0] upd1_type = 0, upd2_type = 0;
    logic clear_req = 0, wr_ready = 1;
    logic wr_en, wr_clear, wr_taken, busy;
    logic [IDX_W-1:0] wr_idx;
    logic [31:0] wr_pc, wr_target;
    logic [1:0] wr_type;
    logic [$clog2(DEPTH):0] fifo_count;
    logic [CNT_W-1:0] drop_cnt;

    bpu_update_sched #(.DEPTH(DEPTH), .IDX_W(IDX_W), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset),
        .upd1_valid(upd1_valid), .upd1_pc(upd1_pc), .upd1_taken(upd1_taken),
        .upd1_target(upd1_target), .upd1_type(upd1_type),
        .upd2_valid(upd2_valid), .upd2_pc(upd2_pc), .upd2_taken(upd2_taken),
        .upd2_target(upd2_target), .upd2_type(upd2_type),
        .clear_req(clear_req), .wr_ready(wr_ready),
        .wr_en(wr_en), .wr_clear(wr_clear), .wr_idx(wr_idx), .wr_pc(wr_pc),
        .wr_taken(wr_taken), .wr_target(wr_target), .wr_type(wr_type),
        .busy(busy), .fifo_count(fifo_count), .drop_cnt(drop_cnt)
    );

    always #5 clk = ~clk;

    int   checks = 0, errors = 0;
    bit   mon_en = 0;
    ent_t sb[$];
    bit   m_sweep = 1;
    int   m_clr = 0, m_cnt = 0, m_drop = 0;

    function automatic void chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endfunction

    // Reference model: one step per clock edge, a queue of pending writes plus a sweep position
    task automatic model_step();
        int free, drops;
        ent_t e;
        if (reset) begin
            m_sweep = 1; m_clr = 0; m_cnt = 0; m_drop = 0; sb.delete();
        end else if (m_sweep) begin
            if (wr_ready) begin
                if (m_clr == TBL - 1) begin m_sweep = 0; m_clr = 0; end
                else m_clr++;
            end
        end else if (clear_req) begin
            m_sweep = 1; m_clr = 0; m_cnt = 0; sb.delete();
        end else begin
            free = DEPTH - m_cnt;
            drops = 0;
            if (m_cnt > 0 && wr_ready) m_cnt--;
            if (upd1_valid) begin
                if (free > 0) begin
                    e.pc = upd1_pc; e.taken = upd1_taken; e.target = upd1_target; e.typ = upd1_type;
                    sb.push_back(e); m_cnt++; free--;
                end else drops++;
            end
            if (upd2_valid) begin
                if (free > 0) begin
                    e.pc = upd2_pc; e.taken = upd2_taken; e.target = upd2_target; e.typ = upd2_type;
                    sb.push_back(e); m_cnt++; free--;
                end else drops++;
            end
            m_drop = (m_drop + drops > DMAX) ? DMAX : m_drop + drops;
        end
    endtask

    initial forever begin
        @(posedge clk);
        model_step();
    end

    // Monitor: on the falling edge compare the presented write against the scoreboard head
    initial forever begin
        @(negedge clk);
        if (mon_en) begin
            chk("busy", busy, m_sweep);
            chk("fifo_count", fifo_count, m_cnt);
            chk("drop_cnt", drop_cnt, m_drop);
            if (m_sweep) begin
                chk("sweep_wr_en", wr_en, 1);
                chk("sweep_wr_clear", wr_clear, 1);
                chk("sweep_wr_idx", wr_idx, m_clr);
                chk("sweep_data", {wr_pc, wr_taken, wr_target, wr_type}, 0);
            end else begin
                chk("wr_clear", wr_clear, 0);
                chk("wr_en", wr_en, m_cnt > 0);
                if (m_cnt > 0) begin
                    if (sb.size() == 0) chk("sb_nonempty", 0, 1);
                    else begin
                        chk("wr_idx", wr_idx, sb[0].pc[IDX_W+1:2]);
                        chk("wr_pc", wr_pc, sb[0].pc);
                        chk("wr_taken", wr_taken, sb[0].taken);
                        chk("wr_target", wr_target, sb[0].target);
                        chk("wr_type", wr_type, sb[0].typ);
                        if (wr_ready) void'(sb.pop_front());
                    end
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic step(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic set_lanes(input int p1, input int p2);
        upd1_valid = $urandom_range(99) < p1;
        upd1_pc = $urandom; upd1_taken = 1'($urandom); upd1_target = $urandom; upd1_type = 2'($urandom_range(2));
        upd2_valid = $urandom_range(99) < p2;
        upd2_pc = $urandom; upd2_taken = 1'($urandom); upd2_target = $urandom; upd2_type = 2'($urandom_range(2));
    endtask

    task automatic wait_idle();
        int i;
        for (i = 0; i < 2000 && (busy || fifo_count != 0); i++) step(1);
        chk("idle_reached", {busy, fifo_count}, 0);
    endtask

    initial begin
        step(2);
        reset = 0;
        mon_en = 1;
        // sweep after reset at full write rate
        step(TBL);
        chk("sweep_len_busy", busy, 0);
        chk("sweep_len_wr_en", wr_en, 0);
        // single update
        upd1_valid = 1; upd1_pc = 32'h1C000104; upd1_taken = 1; upd1_target = 32'h1C000200; upd1_type = 2'b01;
        step(1);
        set_lanes(0, 0);
        chk("single_idx", wr_idx, 7'h41);
        chk("single_target", wr_target, 32'h1C000200);
        chk("single_count", fifo_count, 1);
        step(1);
        chk("single_drained", wr_en, 0);
        // dual-lane ordering
        set_lanes(100, 100);
        upd1_pc = 32'h1C000010; upd2_pc = 32'h1C000014;
        step(1);
        set_lanes(0, 0);
        chk("dual_first", wr_idx, 7'h04);
        step(1);
        chk("dual_second", wr_idx, 7'h05);
        step(2);
        // overflow with a stalled table
        wr_ready = 0;
        set_lanes(100, 100);
        step(4);
        chk("ovf_full", fifo_count, 8);
        step(1);
        chk("ovf_drop2", drop_cnt, 2);
        set_lanes(0, 0);
        wr_ready = 1;
        step(1);
        chk("ovf_one_deq", fifo_count, 7);
        wr_ready = 0;
        set_lanes(100, 100);
        step(1);
        chk("ovf_drop3", drop_cnt, 3);
        chk("ovf_refill", fifo_count, 8);
        set_lanes(0, 0);
        wr_ready = 1;
        wait_idle();
        // stall hold while new updates arrive
        wr_ready = 0;
        repeat (10) begin set_lanes(30, 30); step(1); end
        set_lanes(0, 0);
        wr_ready = 1;
        wait_idle();
        // clear with pending entries
        wr_ready = 0;
        repeat (3) begin set_lanes(100, 0); step(1); end
        set_lanes(60, 60);
        clear_req = 1;
        wr_ready = 1;
        step(1);
        clear_req = 0;
        set_lanes(50, 50);
        chk("clear_count", fifo_count, 0);
        chk("clear_busy", busy, 1);
        chk("clear_drop_kept", drop_cnt, 3);
        step(3);
        set_lanes(0, 0);
        wait_idle();
        // random traffic with occasional clears and resets
        for (int i = 0; i < 4000; i++) begin
            set_lanes(50, 50);
            wr_ready = $urandom_range(99) < 70;
            clear_req = $urandom_range(399) == 0;
            reset = $urandom_range(1499) == 0;
            step(1);
        end
        reset = 0; clear_req = 0; wr_ready = 1;
        set_lanes(0, 0);
        wait_idle();
        // drop counter saturation
        wr_ready = 0;
        set_lanes(100, 100);
        step(25);
        chk("drop_sat", drop_cnt, DMAX);
        set_lanes(0, 0);
        wr_ready = 1;
        wait_idle();
        step(2);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
